serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-005 sub  input  1  mode: 0 = a+b+cin, 1 = a-b (two's complement).
REQ-006 a  input  WIDTH  operand A, sampled on the accepting edge.
REQ-007 b  input  WIDTH  operand B, sampled on the accepting edge.
REQ-008 cin  input  1  carry-in for add; ignored when sub=1.
REQ-009 busy  output  1  high while state is RUN.
REQ-010 done  output  1  one-cycle pulse; result registers valid.
REQ-011 sum  output  WIDTH  result, registered.
REQ-012 cout  output  1  carry out of MSB (sub mode: 1 = no borrow).
REQ-013 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE/DONE with start=1: latch a, b (b inverted if sub=1), carry = sub ? 1 : cin, clear bit counter, go RUN.
REQ-016 DONE with start=0 SHALL go IDLE; DONE lasts exactly one cycle unless restarted.
REQ-017 RUN SHALL process one bit per cycle, LSB first, through one full-adder instance; carry register updated each cycle.
REQ-018 The bit counter SHALL be $clog2(WIDTH) bits, count 0..WIDTH-1, no wrap beyond WIDTH-1.
REQ-019 On the RUN cycle with counter = WIDTH-1, next state SHALL be DONE and sum/cout/ovf SHALL be loaded at that same edge.
REQ-020 Latency: start accepted at edge 0 -> done=1 and valid result in the cycle after edge WIDTH.
REQ-021 start during RUN SHALL be ignored; a, b, sub, cin changes during RUN SHALL have no effect.
REQ-022 sum, cout, ovf SHALL hold the previous result throughout RUN and IDLE until the next DONE load.
REQ-023 done SHALL be high only in DONE; busy only in RUN; never both high.
REQ-024 Back-to-back: start=1 in DONE SHALL re-enter RUN with no idle cycle; done still pulses for the finished operation.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, internal carry/shift registers=0.
REQ-026 Reset during RUN SHALL abandon the operation; no done pulse SHALL follow.
REQ-027 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package serial_adder_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default.
REQ-029 The per-bit add SHALL be one instance of the existing fulladder sub-module (ports a, b, c, sum, carry).
REQ-030 Operand and result shift registers and the counter SHALL live in serial_adder; no further sub-modules.

Verification (WIDTH=8)
REQ-031 a=0x0F, b=0x01, sub=0, cin=0, start 1 cycle -> busy 8 cycles, done pulse, sum=0x10, cout=0, ovf=0.
REQ-032 a=0xFF, b=0x01, sub=0, cin=1 -> sum=0x01, cout=1, ovf=0; a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1.
REQ-033 a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1.
REQ-034 start held high continuously with changing operands -> a new op every 9 cycles, each result matches operands on its accepting edge; mid-RUN changes ignored.
REQ-035 rst_n low at RUN cycle 4 -> outputs zero immediately, no done; fresh start after release completes correctly.
REQ-036 Randomised 1000 ops both modes vs. reference model; check sum/cout/ovf, done count = accepted start count.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    // Default operand/result width in bits.
    localparam int WIDTH_DEFAULT = 8;

    // FSM state encoding.
    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder used as the per-bit arithmetic slice of the serial adder.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule : fulladder

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a single
// full adder. The result registers are loaded on the last RUN edge and hold
// until the next operation completes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic               carry_q,  carry_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;

    logic               fa_sum;
    logic               fa_carry;
    logic               load_op;

    // The one and only arithmetic slice: current LSBs plus the running carry.
    fulladder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // A new operation is accepted only while idle or in the done cycle.
    assign load_op = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state, datapath shifting and result capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                // Shift operands right; the new result bit enters at the MSB so
                // that after WIDTH steps the first bit computed sits at bit 0.
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_carry;
                res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    sum_d   = {fa_sum, res_sh_q[WIDTH-1:1]};
                    cout_d  = fa_carry;
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ fa_carry;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accepting a new operation overrides the idle/done defaults above.
        // Subtraction is a + ~b + 1, so invert b and force the carry-in.
        if (load_op) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            a_sh_d   = a;
            b_sh_d   = sub ? ~b : b;
            carry_d  = sub ? 1'b1 : cin;
            res_sh_d = '0;
        end
    end

    // State and datapath registers; reset clears everything and abandons any op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed vectors, back-to-back
// operation, reset mid-run and randomized operations against an arithmetic model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int total;
    int bad;
    int done_cnt;
    int start_cnt;

    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse seen (one sample per cycle, away from the active edge).
    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                  input logic sub_i, input logic cin_i,
                                  output logic [W-1:0] s_o, output logic c_o,
                                  output logic v_o);
        int sa, sb, r, ua, ub, ur;
        sa = int'($signed(a_i));
        sb = int'($signed(b_i));
        ua = int'(a_i);
        ub = int'(b_i);
        if (sub_i) begin
            r   = sa - sb;
            ur  = ua - ub;
            c_o = (ua >= ub);
        end else begin
            r   = sa + sb + int'(cin_i);
            ur  = ua + ub + int'(cin_i);
            c_o = (ur > 255);
        end
        s_o = W'(ur);
        v_o = (r > 127) || (r < -128);
    endfunction

    task automatic randomize_inputs();
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
        cin = 1'($urandom);
    endtask

    // One complete operation, called just after a falling edge.
    task automatic do_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         input logic sub_i, input logic cin_i);
        logic [W-1:0] es;
        logic         ec, ev;
        int           n;
        model(a_i, b_i, sub_i, cin_i, es, ec, ev);
        a = a_i; b = b_i; sub = sub_i; cin = cin_i; start = 1'b1;
        start_cnt = start_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n = n + 1;
            if (n == 4) begin
                check("hold_sum", sum, prev_sum);
                check("hold_cout", cout, prev_cout);
                check("hold_ovf", ovf, prev_ovf);
                check("no_done_in_run", done, 1'b0);
            end
            // Operand and start activity during RUN must not disturb the op.
            randomize_inputs();
            start = 1'($urandom);
            @(negedge clk);
            start = 1'b0;
        end
        check("busy_cycles", n, W);
        check("done", done, 1'b1);
        check("busy_in_done", busy, 1'b0);
        check("sum", sum, es);
        check("cout", cout, ec);
        check("ovf", ovf, ev);
        $display("op a=%02h b=%02h sub=%0d cin=%0d -> sum=%02h cout=%0d ovf=%0d (exp %02h %0d %0d)",
                 a_i, b_i, sub_i, cin_i, sum, cout, ovf, es, ec, ev);
        prev_sum = es; prev_cout = ec; prev_ovf = ev;
        @(negedge clk);
        check("done_pulse_end", done, 1'b0);
        check("idle_not_busy", busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] es;
        logic         ec, ev;
        int           d0, s0;

        total = 0; bad = 0; done_cnt = 0; start_cnt = 0;
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;

        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // First start straight after reset release.
        do_op(8'h0F, 8'h01, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b1);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0);
        do_op(8'h05, 8'h07, 1'b1, 1'b1);
        do_op(8'h80, 8'h01, 1'b1, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0, 1'b1);

        // Back-to-back: start held high, operands changing every cycle.
        for (int op = 0; op < 5; op++) begin
            for (int c = 0; c <= W; c++) begin
                randomize_inputs();
                start = 1'b1;
                if (c == 0) begin
                    model(a, b, sub, cin, es, ec, ev);
                    start_cnt = start_cnt + 1;
                end
                @(negedge clk);
                if (c < W) begin
                    check("b2b_busy", busy, 1'b1);
                    check("b2b_no_done", done, 1'b0);
                end else begin
                    check("b2b_done", done, 1'b1);
                    check("b2b_sum", sum, es);
                    check("b2b_cout", cout, ec);
                    check("b2b_ovf", ovf, ev);
                    $display("b2b op %0d -> sum=%02h cout=%0d ovf=%0d (exp %02h %0d %0d)",
                             op, sum, cout, ovf, es, ec, ev);
                end
            end
        end
        start = 1'b0;
        prev_sum = es; prev_cout = ec; prev_ovf = ev;
        @(negedge clk);
        check("b2b_end_idle", busy, 1'b0);
        check("b2b_end_done", done, 1'b0);

        // Reset in the middle of RUN abandons the operation.
        a = 8'h3C; b = 8'h5A; sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_sum", sum, '0);
        check("arst_cout", cout, 1'b0);
        check("arst_ovf", ovf, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_done", done, 1'b0);
        end
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        rst_n = 1'b1;
        do_op(8'h12, 8'h34, 1'b0, 1'b1);
        $display("reset-mid-run recovery done");

        // Randomized operations, both modes, with random idle gaps.
        d0 = done_cnt;
        s0 = start_cnt;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        check("done_count", done_cnt - d0, start_cnt - s0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so a stuck design still reaches a verdict.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_serial_adder
